// File: rtl/oam_dma_controller.sv
// Sprite (OAM) DMA engine: a CPU write to $4014 stalls the CPU and copies one 256-byte
// page to OAMDATA as alternating read/write bus cycles.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic [15:0] i_address_cpu,
    input  logic        i_rw_cpu,
    input  logic [7:0]  i_data_cpu,
    input  logic [7:0]  i_data_bus,
    output logic        o_cpu_ce,
    output logic        o_dma_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    output logic [7:0]  o_debug_index
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_t;

    state_t     r_state;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_byte;
    logic       r_odd;
    logic       w_trigger;

    assign w_trigger = (i_rw_cpu == 1'b0) && (i_address_cpu == DMA_REG_ADDR);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_page  <= 8'h00;
            r_index <= 8'h00;
            r_byte  <= 8'h00;
            r_odd   <= 1'b0;
        end else if (i_clk_en) begin
            r_odd <= ~r_odd;
            case (r_state)
                StIdle: begin
                    if (w_trigger) begin
                        r_page  <= i_data_cpu;
                        r_index <= 8'h00;
                        r_state <= StHalt;
                    end
                end
                // Reads must land on even cycles; an odd next cycle needs one extra dummy.
                StHalt:  r_state <= r_odd ? StRead : StAlign;
                StAlign: r_state <= StRead;
                StRead: begin
                    r_byte  <= i_data_bus;
                    r_state <= StWrite;
                end
                StWrite: begin
                    r_index <= r_index + 8'h01;
                    r_state <= (r_index == 8'hFF) ? StIdle : StRead;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_dma_active = 1'b0;
        o_address    = 16'h0000;
        o_rw         = 1'b1;
        o_data       = r_byte;
        case (r_state)
            StHalt, StAlign: begin
                o_dma_active = 1'b1;
                o_address    = DMA_REG_ADDR;
            end
            StRead: begin
                o_dma_active = 1'b1;
                o_address    = {r_page, r_index};
            end
            StWrite: begin
                o_dma_active = 1'b1;
                o_address    = OAMDATA_ADDR;
                o_rw         = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_cpu_ce      = i_clk_en & ~o_dma_active;
    assign o_debug_index = r_index;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: expected bus traffic is queued at trigger time
// and compared against what a negedge monitor records.
module tb_oam_dma_controller;

    localparam logic [15:0] DMA = 16'h4014;
    localparam logic [15:0] OAM = 16'h2004;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_clk_en;
    logic [15:0] i_address_cpu;
    logic        i_rw_cpu;
    logic [7:0]  i_data_cpu;
    logic [7:0]  i_data_bus;
    logic        o_cpu_ce;
    logic        o_dma_active;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [7:0]  o_debug_index;

    int checks   = 0;
    int failures = 0;
    int en_div   = 1;
    int ce_cnt   = 0;
    int stall    = 0;
    bit tb_odd   = 1'b0;

    logic [15:0] obs_wr_addr[$];
    logic [7:0]  obs_wr_data[$];
    logic [15:0] obs_rd_addr[$];
    bit          obs_rd_par[$];
    logic [15:0] exp_rd_addr[$];
    logic [7:0]  exp_wr_data[$];

    oam_dma_controller dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_clk_en      (i_clk_en),
        .i_address_cpu (i_address_cpu),
        .i_rw_cpu      (i_rw_cpu),
        .i_data_cpu    (i_data_cpu),
        .i_data_bus    (i_data_bus),
        .o_cpu_ce      (o_cpu_ce),
        .o_dma_active  (o_dma_active),
        .o_address     (o_address),
        .o_rw          (o_rw),
        .o_data        (o_data),
        .o_debug_index (o_debug_index)
    );

    // Memory model: each byte is its low address byte XOR A5.
    always_comb i_data_bus = o_address[7:0] ^ 8'hA5;

    initial forever #5 i_clk = ~i_clk;

    initial begin
        i_clk_en = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            ce_cnt   = (ce_cnt + 1) % en_div;
            i_clk_en = (ce_cnt == 0);
        end
    end

    // Records every enabled bus cycle; tb_odd tracks the parity of the cycle being observed.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            tb_odd = 1'b0;
        end else if (i_clk_en) begin
            if (!o_cpu_ce) stall++;
            if (o_dma_active && !o_rw) begin
                obs_wr_addr.push_back(o_address);
                obs_wr_data.push_back(o_data);
            end else if (o_dma_active && o_address != DMA) begin
                obs_rd_addr.push_back(o_address);
                obs_rd_par.push_back(tb_odd);
            end
            tb_odd = ~tb_odd;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_wr_addr.delete();
        obs_wr_data.delete();
        obs_rd_addr.delete();
        obs_rd_par.delete();
        exp_rd_addr.delete();
        exp_wr_data.delete();
        stall = 0;
    endtask

    // One CPU cycle on an enabled clock whose parity matches par (2 = any); used = parity taken.
    task automatic cpu_access(input logic [15:0] addr, input logic [7:0] data, input logic rw,
                              input int par, output int used);
        used = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #2;
            if (i_clk_en && (par == 2 || int'(tb_odd) == par)) begin
                used          = int'(tb_odd);
                i_address_cpu = addr;
                i_rw_cpu      = rw;
                i_data_cpu    = data;
                @(posedge i_clk);
                #2;
                i_address_cpu = 16'h0000;
                i_rw_cpu      = 1'b1;
                i_data_cpu    = 8'h00;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge i_clk);
            #2;
            if (!o_dma_active) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_dma_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_active: got %b want 0", o_dma_active);
        end
        checks++;
        if (o_rw !== 1'b1) begin
            failures++;
            $display("FAIL reset_rw: got %b want 1", o_rw);
        end
        checks++;
        if (o_address !== 16'h0000) begin
            failures++;
            $display("FAIL reset_address: got %h want 0000", o_address);
        end
        checks++;
        if (o_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h want 00", o_data);
        end
        checks++;
        if (o_cpu_ce !== i_clk_en) begin
            failures++;
            $display("FAIL reset_cpu_ce: got %b want %b", o_cpu_ce, i_clk_en);
        end
        checks++;
        if (o_debug_index !== 8'h00) begin
            failures++;
            $display("FAIL reset_index: got %h want 00", o_debug_index);
        end
    endtask

    // Full page transfer; par picks trigger-cycle parity, retrig holds a $4014 write mid-copy.
    task automatic test_transfer(input string name, input logic [7:0] page, input int par,
                                 input bit retrig);
        int          used;
        int          exp_stall;
        bit          timed_out;
        logic [15:0] ea;
        logic [15:0] oa;
        logic [7:0]  ed;
        logic [7:0]  od;
        bit          op;
        clear_obs();
        cpu_access(DMA, page, 1'b0, par, used);
        checks++;
        if (used < 0) begin
            failures++;
            $display("FAIL %s_trigger: no enabled cycle with parity %0d", name, par);
            return;
        end
        // Trigger on odd puts HALT on even, so ALIGN is needed before the first read.
        exp_stall = (used == 1) ? 514 : 513;
        for (int n = 0; n < 256; n++) begin
            logic [7:0] nb;
            nb = n[7:0];
            exp_rd_addr.push_back({page, nb});
            exp_wr_data.push_back(nb ^ 8'hA5);
        end
        if (retrig) begin
            i_address_cpu = DMA;
            i_rw_cpu      = 1'b0;
            i_data_cpu    = 8'h77;
            repeat (40) @(posedge i_clk);
            #2;
            i_address_cpu = 16'h0000;
            i_rw_cpu      = 1'b1;
            i_data_cpu    = 8'h00;
        end
        wait_idle(timed_out);
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL %s_done: o_dma_active still 1 after cycle budget", name);
        end
        checks++;
        if (stall != exp_stall) begin
            failures++;
            $display("FAIL %s_stall: got %0d want %0d", name, stall, exp_stall);
        end
        checks++;
        if (obs_wr_data.size() != 256) begin
            failures++;
            $display("FAIL %s_write_count: got %0d want 256", name, obs_wr_data.size());
        end
        checks++;
        if (obs_rd_addr.size() != 256) begin
            failures++;
            $display("FAIL %s_read_count: got %0d want 256", name, obs_rd_addr.size());
        end
        while (exp_rd_addr.size() > 0 && obs_rd_addr.size() > 0 && obs_wr_data.size() > 0) begin
            ea = exp_rd_addr.pop_front();
            ed = exp_wr_data.pop_front();
            oa = obs_rd_addr.pop_front();
            op = obs_rd_par.pop_front();
            od = obs_wr_data.pop_front();
            checks++;
            if (oa !== ea) begin
                failures++;
                $display("FAIL %s_read_addr: got %h want %h", name, oa, ea);
            end
            checks++;
            if (op !== 1'b0) begin
                failures++;
                $display("FAIL %s_read_parity at %h: got odd want even", name, ea);
            end
            checks++;
            if (od !== ed) begin
                failures++;
                $display("FAIL %s_write_data for %h: got %h want %h", name, ea, od, ed);
            end
            oa = obs_wr_addr.pop_front();
            checks++;
            if (oa !== OAM) begin
                failures++;
                $display("FAIL %s_write_addr: got %h want %h", name, oa, OAM);
            end
        end
        checks++;
        if (o_debug_index !== 8'h00) begin
            failures++;
            $display("FAIL %s_index_wrap: got %h want 00", name, o_debug_index);
        end
        checks++;
        if (o_cpu_ce !== i_clk_en) begin
            failures++;
            $display("FAIL %s_cpu_resume: got %b want %b", name, o_cpu_ce, i_clk_en);
        end
    endtask

    task automatic test_non_trigger();
        int used;
        clear_obs();
        cpu_access(DMA, 8'h02, 1'b1, 2, used);
        cpu_access(16'h4015, 8'h02, 1'b0, 2, used);
        repeat (10) @(posedge i_clk);
        #2;
        checks++;
        if (o_dma_active !== 1'b0) begin
            failures++;
            $display("FAIL non_trigger_active: got %b want 0", o_dma_active);
        end
        checks++;
        if (stall != 0) begin
            failures++;
            $display("FAIL non_trigger_stall: got %0d want 0", stall);
        end
        checks++;
        if (obs_wr_data.size() != 0) begin
            failures++;
            $display("FAIL non_trigger_writes: got %0d want 0", obs_wr_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int used;
        clear_obs();
        cpu_access(DMA, 8'h07, 1'b0, 2, used);
        repeat (100) @(posedge i_clk);
        #2;
        checks++;
        if (o_dma_active !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_started: got %b want 1", o_dma_active);
        end
        i_reset_n = 1'b0;
        #1;
        test_reset();
        repeat (3) @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        clear_obs();
        repeat (600) @(posedge i_clk);
        #2;
        checks++;
        if (obs_wr_data.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_writes: got %0d want 0", obs_wr_data.size());
        end
        checks++;
        if (stall != 0) begin
            failures++;
            $display("FAIL reset_mid_stall: got %0d want 0", stall);
        end
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_address_cpu = 16'h0000;
        i_rw_cpu      = 1'b1;
        i_data_cpu    = 8'h00;
        repeat (3) @(posedge i_clk);
        #2;
        test_reset();
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        test_transfer("even", 8'h02, 0, 1'b0);
        test_transfer("odd", 8'h02, 1, 1'b0);
        test_transfer("page_ff", 8'hFF, 0, 1'b0);
        test_transfer("retrigger", 8'h03, 1, 1'b1);
        test_transfer("back_to_back", 8'h10, 2, 1'b0);
        test_non_trigger();
        en_div = 3;
        test_transfer("gaps_a", 8'h05, 0, 1'b0);
        test_transfer("gaps_b", 8'h06, 1, 1'b0);
        en_div = 1;
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
